// File: rtl/muon_trig_pkg.sv
// Shared types and constants for the muon pair trigger: FSM states, edge-path latency
// and the event-record layout used by consumers of the trigger output.
package muon_trig_pkg;

    localparam int EDGE_LAT   = 3;
    localparam int REC_CNT_W  = 16;
    localparam int REC_MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        REPORT  = 2'd2,
        HOLDOFF = 2'd3
    } trig_state_t;

    typedef struct packed {
        logic [REC_CNT_W-1:0]  delta;
        logic [REC_MAX_CH-1:0] ch_first;
        logic [REC_MAX_CH-1:0] ch_second;
    } ev_rec_t;

endpackage

// File: rtl/muon_pair_trigger_edge_sync_filter.sv
// Per-channel synchroniser and rise filter: a rise is one low sample followed by two
// consecutive high samples, which rejects single-sample glitches on the discriminator.
module edge_sync_filter #(
    parameter int SYNC_STG = 3
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_rise;

    // Taps sit on the three oldest stages, so extra depth adds latency equally to both pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync <= '0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_async};
            r_rise <= ~r_sync[SYNC_STG-1] & r_sync[SYNC_STG-2] & r_sync[SYNC_STG-3];
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/muon_pair_trigger.sv
// Muon pair trigger: detects a first/second discriminator pulse pair within [min_dt, window]
// and reports it over valid/ready. Define MUON_PAIR_TIMESTAMP_EN to add a 48-bit first-pulse timestamp.
module muon_pair_trigger
    import muon_trig_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 16,
    parameter int SYNC_STG = 3,
    parameter int STAT_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_enable,
    input  logic [N_CH-1:0]   i_trig_in,
    input  logic [CNT_W-1:0]  i_window,
    input  logic [CNT_W-1:0]  i_min_dt,
    input  logic [CNT_W-1:0]  i_holdoff,
    output logic              o_ev_valid,
    input  logic              i_ev_ready,
    output logic [CNT_W-1:0]  o_ev_delta,
    output logic [N_CH-1:0]   o_ev_ch_first,
    output logic [N_CH-1:0]   o_ev_ch_second,
    output logic              o_double_trig,
    output logic              o_busy,
    output logic [STAT_W-1:0] o_single_cnt,
    output logic [STAT_W-1:0] o_double_cnt,
    output logic [STAT_W-1:0] o_lost_cnt
`ifdef MUON_PAIR_TIMESTAMP_EN
    ,
    output logic [47:0]       o_ev_tstamp
`endif
);

    logic [N_CH-1:0]   w_edge;
    logic              w_any_edge;
    logic [CNT_W-1:0]  w_dnext;
    logic [CNT_W-1:0]  w_hnext;
    logic              w_in_window;

    trig_state_t       r_state;
    logic [CNT_W-1:0]  r_dcnt;
    logic [CNT_W-1:0]  r_hcnt;
    logic [CNT_W-1:0]  r_ev_delta;
    logic [N_CH-1:0]   r_ch_first;
    logic [N_CH-1:0]   r_ch_second;
    logic              r_ev_valid;
    logic              r_double_trig;
    logic              r_busy;
    logic [STAT_W-1:0] r_single_cnt;
    logic [STAT_W-1:0] r_double_cnt;
    logic [STAT_W-1:0] r_lost_cnt;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_sync_filter #(
            .SYNC_STG (SYNC_STG)
        ) u_filter (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .i_async (i_trig_in[g]),
            .o_rise  (w_edge[g])
        );
    end

    // Delta saturates so an all-ones window never times out.
    assign w_any_edge  = |w_edge;
    assign w_dnext     = (r_dcnt == '1) ? r_dcnt : r_dcnt + CNT_W'(1);
    assign w_hnext     = r_hcnt + CNT_W'(1);
    assign w_in_window = (w_dnext >= i_min_dt) && (w_dnext <= i_window);

`ifdef MUON_PAIR_TIMESTAMP_EN
    logic [47:0] r_tstamp;
    logic [47:0] r_ev_tstamp;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_tstamp <= '0;
        else         r_tstamp <= r_tstamp + 48'd1;
    end

    assign o_ev_tstamp = r_ev_tstamp;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state       <= IDLE;
            r_dcnt        <= '0;
            r_hcnt        <= '0;
            r_ev_delta    <= '0;
            r_ch_first    <= '0;
            r_ch_second   <= '0;
            r_ev_valid    <= 1'b0;
            r_double_trig <= 1'b0;
            r_busy        <= 1'b0;
            r_single_cnt  <= '0;
            r_double_cnt  <= '0;
            r_lost_cnt    <= '0;
`ifdef MUON_PAIR_TIMESTAMP_EN
            r_ev_tstamp   <= '0;
`endif
        end else begin
            r_double_trig <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_edge && i_enable && (i_window != '0)) begin
                        r_ch_first <= w_edge;
                        r_dcnt     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ARMED;
`ifdef MUON_PAIR_TIMESTAMP_EN
                        r_ev_tstamp <= r_tstamp;
`endif
                    end
                end
                ARMED: begin
                    if (!i_enable) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_any_edge && w_in_window) begin
                        r_ev_delta    <= w_dnext;
                        r_ch_second   <= w_edge;
                        r_double_trig <= 1'b1;
                        r_ev_valid    <= 1'b1;
                        r_double_cnt  <= r_double_cnt + STAT_W'(r_double_cnt != '1);
                        r_state       <= REPORT;
                    end else if (w_dnext > i_window) begin
                        r_single_cnt <= r_single_cnt + STAT_W'(r_single_cnt != '1);
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        // Early edges inside the afterpulse veto still widen the first-pulse mask.
                        if (w_any_edge) r_ch_first <= r_ch_first | w_edge;
                        r_dcnt <= w_dnext;
                    end
                end
                REPORT: begin
                    if (w_any_edge) r_lost_cnt <= r_lost_cnt + STAT_W'(r_lost_cnt != '1);
                    if (i_ev_ready) begin
                        r_ev_valid <= 1'b0;
                        r_hcnt     <= '0;
                        if (i_holdoff == '0) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    if (w_any_edge) r_lost_cnt <= r_lost_cnt + STAT_W'(r_lost_cnt != '1);
                    if (!i_enable || (w_hnext >= i_holdoff)) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hcnt <= w_hnext;
                    end
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_ev_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign o_ev_valid     = r_ev_valid;
    assign o_ev_delta     = r_ev_delta;
    assign o_ev_ch_first  = r_ch_first;
    assign o_ev_ch_second = r_ch_second;
    assign o_double_trig  = r_double_trig;
    assign o_busy         = r_busy;
    assign o_single_cnt   = r_single_cnt;
    assign o_double_cnt   = r_double_cnt;
    assign o_lost_cnt     = r_lost_cnt;

endmodule
